filtered_edge_counter: RTL and testbench

FILTERED_EDGE_COUNTER -- requirements
Module: filtered_edge_counter

---
 rtl/filtered_edge_counter.sv | 124 ++++++++++++
 tb/tb_filtered_edge_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/filtered_edge_counter.sv
// Multi-channel input debouncer: each channel accepts a level change only after
// FILT_LEN consecutive differing samples, pulses q on selected edges and counts them.
module filtered_edge_counter #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned FILT_LEN  = 5,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned EDGE_MODE = 0,
    parameter int unsigned SATURATE  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [N_CH-1:0]         clr,
    input  logic [N_CH-1:0]         d,
    output logic [N_CH-1:0]         level,
    output logic [N_CH-1:0]         q,
    output logic [N_CH*CNT_W-1:0]   pulse_count,
    output logic [N_CH-1:0]         ovf
);

    localparam int unsigned         STAB_W    = $clog2(FILT_LEN) + 32'd1;
    localparam logic [STAB_W-1:0]   STAB_LAST = STAB_W'(FILT_LEN - 32'd1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};

    logic [N_CH-1:0]   flt_q, flt_d;
    logic [N_CH-1:0]   q_q, q_d;
    logic [N_CH-1:0]   ovf_q, ovf_d;
    logic [N_CH-1:0]   commit_s;
    logic [STAB_W-1:0] stab_q [N_CH];
    logic [STAB_W-1:0] stab_d [N_CH];
    logic [CNT_W-1:0]  cnt_q  [N_CH];
    logic [CNT_W-1:0]  cnt_d  [N_CH];

    // new_lvl is the freshly committed level; 0 means a falling transition
    function automatic logic edge_match(input logic new_lvl);
        logic m;
        case (EDGE_MODE)
            32'd0:   m = ~new_lvl;
            32'd1:   m = new_lvl;
            32'd2:   m = 1'b1;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Stability filter and edge pulse generation
    always_comb begin
        flt_d    = flt_q;
        q_d      = {N_CH{1'b0}};
        commit_s = {N_CH{1'b0}};
        for (int unsigned i = 32'd0; i < N_CH; i++) begin
            stab_d[i] = stab_q[i];
            if (en) begin
                if (d[i] == flt_q[i]) begin
                    stab_d[i] = {STAB_W{1'b0}};
                end else if (stab_q[i] == STAB_LAST) begin
                    flt_d[i]    = d[i];
                    stab_d[i]   = {STAB_W{1'b0}};
                    commit_s[i] = 1'b1;
                end else begin
                    stab_d[i] = stab_q[i] + STAB_W'(1);
                end
            end else begin
                stab_d[i] = stab_q[i];
            end
            q_d[i] = commit_s[i] & edge_match(d[i]);
        end
    end

    // Pulse counters; clear wins over a coincident increment
    always_comb begin
        ovf_d = ovf_q;
        for (int unsigned i = 32'd0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
                ovf_d[i] = 1'b0;
            end else if (q_d[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = (SATURATE != 32'd0) ? CNT_MAX : {CNT_W{1'b0}};
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            flt_q <= {N_CH{1'b0}};
            q_q   <= {N_CH{1'b0}};
            ovf_q <= {N_CH{1'b0}};
            for (int unsigned i = 32'd0; i < N_CH; i++) begin
                stab_q[i] <= {STAB_W{1'b0}};
                cnt_q[i]  <= {CNT_W{1'b0}};
            end
        end else begin
            flt_q <= flt_d;
            q_q   <= q_d;
            ovf_q <= ovf_d;
            for (int unsigned i = 32'd0; i < N_CH; i++) begin
                stab_q[i] <= stab_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    // Flatten counters onto the output bus
    always_comb begin
        pulse_count = {(N_CH*CNT_W){1'b0}};
        for (int unsigned i = 32'd0; i < N_CH; i++) begin
            pulse_count[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign level = flt_q;
    assign q     = q_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_filtered_edge_counter.sv
// Bench for filtered_edge_counter: two instances (falling/wrap and both-edges/saturate)
// checked every cycle against a sample-history reference model.
module tb_filtered_edge_counter;

    localparam int N_CH     = 4;
    localparam int FILT_LEN = 5;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset, en;
    logic [N_CH-1:0]       clr, d;
    logic [N_CH-1:0]       level0, q0, ovf0, level1, q1, ovf1;
    logic [N_CH*CNT_W-1:0] pc0, pc1;

    filtered_edge_counter #(.N_CH(N_CH), .FILT_LEN(FILT_LEN), .CNT_W(CNT_W),
                            .EDGE_MODE(0), .SATURATE(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d),
        .level(level0), .q(q0), .pulse_count(pc0), .ovf(ovf0));

    filtered_edge_counter #(.N_CH(N_CH), .FILT_LEN(FILT_LEN), .CNT_W(CNT_W),
                            .EDGE_MODE(2), .SATURATE(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d),
        .level(level1), .q(q1), .pulse_count(pc1), .ovf(ovf1));

    int n_vec = 0;
    int n_err = 0;

    // Reference state: recent enabled samples per channel plus per-instance counters
    bit [31:0] hist     [N_CH];
    int        hist_len [N_CH];
    bit        m_level  [N_CH];
    bit        m_q      [2][N_CH];
    bit        m_ovf    [2][N_CH];
    int        m_cnt    [2][N_CH];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit counts_edge(input int k, input bit new_lvl);
        if (k == 0) return !new_lvl;
        return 1'b1;
    endfunction

    task automatic model_update();
        for (int i = 0; i < N_CH; i++) begin
            bit accepted = 1'b0;
            if (reset) begin
                m_level[i]  = 1'b0;
                hist_len[i] = 0;
                for (int k = 0; k < 2; k++) begin
                    m_q[k][i] = 1'b0; m_cnt[k][i] = 0; m_ovf[k][i] = 1'b0;
                end
            end else begin
                if (en) begin
                    bit all_diff = 1'b1;
                    hist[i] = {hist[i][30:0], d[i]};
                    if (hist_len[i] < 32) hist_len[i]++;
                    for (int j = 0; j < FILT_LEN; j++)
                        if (hist[i][j] == m_level[i]) all_diff = 1'b0;
                    if (hist_len[i] >= FILT_LEN && all_diff) begin
                        m_level[i]  = d[i];
                        hist_len[i] = 0;
                        accepted    = 1'b1;
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    bit ev = accepted && counts_edge(k, m_level[i]);
                    m_q[k][i] = ev;
                    if (clr[i]) begin
                        m_cnt[k][i] = 0; m_ovf[k][i] = 1'b0;
                    end else if (ev) begin
                        if (m_cnt[k][i] == CNT_MAX) begin
                            m_ovf[k][i] = 1'b1;
                            m_cnt[k][i] = (k == 1) ? CNT_MAX : 0;
                        end else begin
                            m_cnt[k][i]++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [N_CH-1:0]       e_lvl, e_q0, e_q1, e_o0, e_o1;
        logic [N_CH*CNT_W-1:0] e_c0, e_c1;
        for (int i = 0; i < N_CH; i++) begin
            int c0 = m_cnt[0][i];
            int c1 = m_cnt[1][i];
            e_lvl[i] = m_level[i];
            e_q0[i]  = m_q[0][i];
            e_q1[i]  = m_q[1][i];
            e_o0[i]  = m_ovf[0][i];
            e_o1[i]  = m_ovf[1][i];
            e_c0[i*CNT_W +: CNT_W] = c0[CNT_W-1:0];
            e_c1[i*CNT_W +: CNT_W] = c1[CNT_W-1:0];
        end
        check_val("level0", 64'(level0), 64'(e_lvl));
        check_val("q0",     64'(q0),     64'(e_q0));
        check_val("count0", 64'(pc0),    64'(e_c0));
        check_val("ovf0",   64'(ovf0),   64'(e_o0));
        check_val("level1", 64'(level1), 64'(e_lvl));
        check_val("q1",     64'(q1),     64'(e_q1));
        check_val("count1", 64'(pc1),    64'(e_c1));
        check_val("ovf1",   64'(ovf1),   64'(e_o1));
    endtask

    task automatic step(input logic [N_CH-1:0] dv, input logic ev,
                        input logic [N_CH-1:0] cv, input logic rv);
        d = dv; en = ev; clr = cv; reset = rv;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        int q_hits;
        int saved;
        logic [N_CH-1:0] hold;
        d = '0; en = 1'b1; clr = '0; reset = 1'b1;
        for (int i = 0; i < N_CH; i++) hist[i] = '0;

        // Reset state
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        check_val("rst_count", 64'(pc0), 64'd0);

        // Accepted rise then fall on ch0
        for (int c = 0; c < 20; c++) begin
            step(4'b0001, 1'b1, 4'b0000, 1'b0);
            if (c == 3) check_val("rise_not_yet", 64'(level0[0]), 64'd0);
            if (c == 4) check_val("rise_5th", 64'(level0[0]), 64'd1);
        end
        check_val("rise_no_count", 64'(pc0[7:0]), 64'd0);
        q_hits = 0;
        for (int c = 0; c < 20; c++) begin
            step(4'b0000, 1'b1, 4'b0000, 1'b0);
            q_hits += int'(q0[0]);
        end
        check_val("fall_q_once", 64'(q_hits), 64'd1);
        check_val("fall_count", 64'(pc0[7:0]), 64'd1);

        // Short glitch is rejected
        repeat (10) step(4'b0001, 1'b1, 4'b0000, 1'b0);
        saved = int'(pc0[7:0]);
        repeat (3)  step(4'b0000, 1'b1, 4'b0000, 1'b0);
        repeat (10) step(4'b0001, 1'b1, 4'b0000, 1'b0);
        check_val("glitch_level", 64'(level0[0]), 64'd1);
        check_val("glitch_count", 64'(pc0[7:0]), 64'(saved));

        // Clear coincident with the edge pulse
        repeat (4) step(4'b0000, 1'b1, 4'b0000, 1'b0);
        step(4'b0000, 1'b1, 4'b0001, 1'b0);
        check_val("clr_q1", 64'(q1[0]), 64'd1);
        check_val("clr_cnt1", 64'(pc1[7:0]), 64'd0);
        check_val("clr_cnt0", 64'(pc0[7:0]), 64'd0);
        for (int c = 0; c < 3; c++) begin
            repeat (8) step(4'b0001, 1'b1, 4'b0000, 1'b0);
            repeat (8) step(4'b0000, 1'b1, 4'b0000, 1'b0);
        end
        check_val("both_edges6", 64'(pc1[7:0]), 64'd6);
        check_val("fall_edges3", 64'(pc0[7:0]), 64'd3);

        // 256 accepted falling edges on ch1: wrap vs saturate
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        for (int c = 0; c < 256; c++) begin
            repeat (6) step(4'b0010, 1'b1, 4'b0000, 1'b0);
            repeat (6) step(4'b0000, 1'b1, 4'b0000, 1'b0);
        end
        check_val("wrap_cnt", 64'(pc0[15:8]), 64'd0);
        check_val("wrap_ovf", 64'(ovf0[1]), 64'd1);
        check_val("sat_cnt", 64'(pc1[15:8]), 64'd255);
        check_val("sat_ovf", 64'(ovf1[1]), 64'd1);

        // Reset mid-filter discards progress
        repeat (3) step(4'b0001, 1'b1, 4'b0000, 1'b0);
        step(4'b0001, 1'b1, 4'b0000, 1'b1);
        check_val("rst_outs", 64'({level0, q0, ovf0, pc0}), 64'd0);
        for (int c = 0; c < 5; c++) begin
            step(4'b0001, 1'b1, 4'b0000, 1'b0);
            if (c == 3) check_val("post_rst_hold", 64'(level0[0]), 64'd0);
        end
        check_val("post_rst_rise", 64'(level0[0]), 64'd1);

        // Enable pause mid-filter, all channels edged together
        step(4'b0000, 1'b1, 4'b0000, 1'b1);
        repeat (2)  step(4'b1111, 1'b1, 4'b0000, 1'b0);
        repeat (10) step(4'b1111, 1'b0, 4'b0000, 1'b0);
        repeat (2)  step(4'b1111, 1'b1, 4'b0000, 1'b0);
        check_val("en_hold", 64'(level0), 64'd0);
        step(4'b1111, 1'b1, 4'b0000, 1'b0);
        check_val("en_resume", 64'(level0), 64'hF);
        check_val("all_rise_cnt", 64'(pc1), 64'h01010101);
        repeat (5) step(4'b0000, 1'b1, 4'b0000, 1'b0);
        check_val("all_fall_cnt", 64'(pc0), 64'h01010101);

        // Randomized traffic with occasional pause, clear and reset
        hold = '0;
        for (int c = 0; c < 3000; c++) begin
            logic [N_CH-1:0] cv;
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 5) == 0) hold[i] = ~hold[i];
                cv[i] = ($urandom_range(0, 31) == 0);
            end
            step(hold, ($urandom_range(0, 9) != 0), cv, ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
